// File: rtl/alu_stack_pkg.sv
// Shared types and constants for the ALU operand-stack sequencer.
//   cmd_kind_e : command encodings carried on cmd_kind
//   ALU_*      : opcodes understood by the team's 8-bit combinational ALU
//   state_e    : sequencer states (IDLE accepts commands, EXEC waits for ALU)
package alu_stack_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH  = 2'd0,
        CMD_OP    = 2'd1,
        CMD_POP   = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_kind_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_NADD = 3'd4;
    localparam logic [2:0] ALU_NSUB = 3'd5;
    localparam logic [2:0] ALU_NAND = 3'd6;
    localparam logic [2:0] ALU_NOR  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_stack_lifo.sv
// Operand LIFO for the ALU stack sequencer.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears depth only)
//   push         : write wdata on top, depth+1 (ignored when full)
//   pop          : drop top entry, depth-1 (ignored when empty)
//   repl_pop     : overwrite next-on-stack with wdata and drop top (needs depth>=2)
//   clear        : depth=0
//   wdata        : data for push / repl_pop
//   depth        : entries in use
//   top, nos     : top-of-stack and next-on-stack, 0 when not present
module alu_stack_lifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          repl_pop,
    input  logic          clear,
    input  logic [DW-1:0] wdata,
    output logic [PW-1:0] depth,
    output logic [DW-1:0] top,
    output logic [DW-1:0] nos
);

    // Entry index width; depth itself needs one more code for "full".
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] depth_r;
    logic [PW-1:0] dm1_s;
    logic [PW-1:0] dm2_s;
    logic          can_push_s;
    logic          can_pop_s;
    logic          can_repl_s;
    logic [DW-1:0] top_s;
    logic [DW-1:0] nos_s;

    // Legality of each request and the read ports
    always_comb begin
        dm1_s      = depth_r - PW'(1);
        dm2_s      = depth_r - PW'(2);
        can_push_s = push && (depth_r < PW'(DEPTH));
        can_pop_s  = pop && (depth_r != PW'(0));
        can_repl_s = repl_pop && (depth_r >= PW'(2));
        if (depth_r != PW'(0)) begin
            top_s = mem_r[dm1_s[AW-1:0]];
        end else begin
            top_s = {DW{1'b0}};
        end
        if (depth_r >= PW'(2)) begin
            nos_s = mem_r[dm2_s[AW-1:0]];
        end else begin
            nos_s = {DW{1'b0}};
        end
    end

    // Storage: not reset; writes suppressed while reset is asserted so an
    // aborted operation never lands in the array
    always_ff @(posedge clk) begin
        if (rst_n && !clear && can_push_s) begin
            mem_r[depth_r[AW-1:0]] <= wdata;
        end else if (rst_n && !clear && can_repl_s) begin
            mem_r[dm2_s[AW-1:0]] <= wdata;
        end
    end

    // Depth pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_r <= PW'(0);
        end else if (clear) begin
            depth_r <= PW'(0);
        end else if (can_push_s) begin
            depth_r <= depth_r + PW'(1);
        end else if (can_pop_s || can_repl_s) begin
            depth_r <= dm1_s;
        end else begin
            depth_r <= depth_r;
        end
    end

    assign depth = depth_r;
    assign top   = top_s;
    assign nos   = nos_s;

endmodule

// File: rtl/alu_stack_ctrl.sv
// Operand-stack sequencer in front of the 8-bit combinational ALU.
// Accepts PUSH/OP/POP/CLEAR over cmd_valid/cmd_ready, keeps operands in a
// LIFO, presents the two top entries to the ALU and writes the result back.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_kind            : 0 PUSH, 1 OP, 2 POP, 3 CLEAR
//   cmd_data, cmd_opc   : PUSH operand, OP opcode
//   alu_opc/alu_a/alu_b : registered ALU inputs (a = next-on-stack, b = top)
//   alu_y               : ALU result, sampled at the end of EXEC
//   top, depth          : top-of-stack (0 when empty), entries in use
//   busy                : OP in flight
//   err                 : sticky overflow/underflow, cleared by CLEAR/reset
module alu_stack_ctrl
    import alu_stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_kind,
    input  logic [DW-1:0]                cmd_data,
    input  logic [2:0]                   cmd_opc,
    output logic [2:0]                   alu_opc,
    output logic [DW-1:0]                alu_a,
    output logic [DW-1:0]                alu_b,
    input  logic [DW-1:0]                alu_y,
    output logic [DW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         busy,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH + 1);

    state_e        state_r;
    state_e        state_nx_s;
    logic          err_r;
    logic          busy_r;
    logic [2:0]    alu_opc_r;
    logic [DW-1:0] alu_a_r;
    logic [DW-1:0] alu_b_r;

    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          repl_s;
    logic          clr_s;
    logic          err_set_s;
    logic          load_alu_s;
    logic [DW-1:0] wdata_s;
    logic [PW-1:0] depth_s;
    logic [DW-1:0] top_s;
    logic [DW-1:0] nos_s;

    alu_stack_lifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .PW    (PW)
    ) u_lifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .pop      (pop_s),
        .repl_pop (repl_s),
        .clear    (clr_s),
        .wdata    (wdata_s),
        .depth    (depth_s),
        .top      (top_s),
        .nos      (nos_s)
    );

    // Ready is gated by reset so nothing is accepted while rst_n is low
    assign cmd_ready = (state_r == ST_IDLE) && rst_n;
    assign accept_s  = cmd_valid && cmd_ready;

    // Next-state and stack-control decode
    always_comb begin
        state_nx_s = state_r;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        repl_s     = 1'b0;
        clr_s      = 1'b0;
        err_set_s  = 1'b0;
        load_alu_s = 1'b0;
        wdata_s    = cmd_data;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_kind_e'(cmd_kind))
                        CMD_PUSH: begin
                            if (depth_s < PW'(DEPTH)) begin
                                push_s = 1'b1;
                            end else begin
                                err_set_s = 1'b1;
                            end
                        end
                        CMD_POP: begin
                            if (depth_s != PW'(0)) begin
                                pop_s = 1'b1;
                            end else begin
                                err_set_s = 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            clr_s = 1'b1;
                        end
                        CMD_OP: begin
                            if (depth_s >= PW'(2)) begin
                                load_alu_s = 1'b1;
                                state_nx_s = ST_EXEC;
                            end else begin
                                err_set_s = 1'b1;
                            end
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Result replaces next-on-stack; top operand is consumed
                repl_s     = 1'b1;
                wdata_s    = alu_y;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, sticky error, busy flag and ALU input registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            alu_opc_r <= 3'd0;
            alu_a_r   <= {DW{1'b0}};
            alu_b_r   <= {DW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_EXEC);
            if (clr_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (load_alu_s) begin
                alu_opc_r <= cmd_opc;
                alu_a_r   <= nos_s;
                alu_b_r   <= top_s;
            end else begin
                alu_opc_r <= alu_opc_r;
                alu_a_r   <= alu_a_r;
                alu_b_r   <= alu_b_r;
            end
        end
    end

    assign alu_opc = alu_opc_r;
    assign alu_a   = alu_a_r;
    assign alu_b   = alu_b_r;
    assign top     = top_s;
    assign depth   = depth_s;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Self-checking bench for alu_stack_ctrl: directed scenarios plus a random
// command stream compared against a queue-based stack model.
module tb_alu_stack_ctrl;
    import alu_stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [DW-1:0] cmd_data;
    logic [2:0]    cmd_opc;
    logic [2:0]    alu_opc;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] top;
    logic [PW-1:0] depth;
    logic          busy;
    logic          err;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [7:0]    mq[$];
    bit            m_err;

    always #5 clk = ~clk;

    // Stand-in for the team ALU (also used by the reference model)
    function automatic logic [7:0] alu_ref(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        logic [7:0] d;
        s = a + b;
        d = a - b;
        case (o)
            ALU_ADD:  return s;
            ALU_SUB:  return d;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_NADD: return ~s;
            ALU_NSUB: return ~d;
            ALU_NAND: return ~(a & b);
            ALU_NOR:  return ~(a | b);
            default:  return 8'h00;
        endcase
    endfunction

    assign alu_y = alu_ref(alu_opc, alu_a, alu_b);

    alu_stack_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_data  (cmd_data),
        .cmd_opc   (cmd_opc),
        .alu_opc   (alu_opc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .top       (top),
        .depth     (depth),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [7:0] m_top();
        return (mq.size() == 0) ? 8'h00 : mq[$];
    endfunction

    // Drive one command, return #1 after its accepting edge, update the model
    task automatic drive_cmd(input logic [1:0] k, input logic [7:0] d, input logic [2:0] o,
                             output bit execd, output logic [7:0] ea, output logic [7:0] eb);
        int guard;
        execd = 1'b0;
        ea    = 8'h00;
        eb    = 8'h00;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind  = k;
        cmd_data  = d;
        cmd_opc   = o;
        while (cmd_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL handshake_timeout cmd_ready=%b required=1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        case (k)
            CMD_PUSH:  if (mq.size() < DEPTH) mq.push_back(d); else m_err = 1'b1;
            CMD_POP:   if (mq.size() > 0) void'(mq.pop_back()); else m_err = 1'b1;
            CMD_CLEAR: begin mq.delete(); m_err = 1'b0; end
            CMD_OP: begin
                if (mq.size() >= 2) begin
                    eb = mq.pop_back();
                    ea = mq.pop_back();
                    mq.push_back(alu_ref(o, ea, eb));
                    execd = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            default: m_err = m_err;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_data = 8'h00; cmd_opc = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, depth, err, busy, alu_opc, alu_a, alu_b, top} !== '0) begin
            $display("FAIL reset_state ready/depth/err/busy/opc/a/b/top=%b/%0d/%b/%b/%0d/%h/%h/%h required all 0",
                     cmd_ready, depth, err, busy, alu_opc, alu_a, alu_b, top);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%b required=1", cmd_ready);
        else n_pass++;
        mq.delete();
        m_err = 1'b0;
    endtask

    task automatic test_sub();
        bit x; logic [7:0] a; logic [7:0] b;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd5, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd3, 3'd0, x, a, b);
        drive_cmd(CMD_OP, 8'h00, ALU_SUB, x, a, b);
        n_checks++;
        if ({busy, cmd_ready, alu_opc, alu_a, alu_b} !== {1'b1, 1'b0, 3'd1, 8'd5, 8'd3}) begin
            $display("FAIL sub_exec busy/ready/opc/a/b=%b/%b/%0d/%0d/%0d required 1/0/1/5/3",
                     busy, cmd_ready, alu_opc, alu_a, alu_b);
        end else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({top, depth, err, busy, cmd_ready} !== {8'd2, PW'(1), 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL sub_result top/depth/err/busy/ready=%0d/%0d/%b/%b/%b required 2/1/0/0/1",
                     top, depth, err, busy, cmd_ready);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        bit x; logic [7:0] a; logic [7:0] b;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'hF0, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'h0F, 3'd0, x, a, b);
        drive_cmd(CMD_OP, 8'h00, ALU_NOR, x, a, b);
        @(posedge clk); #1;
        n_checks++;
        if ({top, depth} !== {8'h00, PW'(1)}) $display("FAIL nor_result top/depth=%h/%0d required 00/1", top, depth);
        else n_pass++;
        drive_cmd(CMD_PUSH, 8'd200, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd100, 3'd0, x, a, b);
        drive_cmd(CMD_OP, 8'h00, ALU_ADD, x, a, b);
        @(posedge clk); #1;
        n_checks++;
        if ({top, depth, err} !== {8'h2C, PW'(2), 1'b0}) $display("FAIL add_wrap top/depth/err=%h/%0d/%b required 2c/2/0", top, depth, err);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit x; logic [7:0] a; logic [7:0] b;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        for (int i = 1; i <= 9; i++) drive_cmd(CMD_PUSH, 8'(i), 3'd0, x, a, b);
        n_checks++;
        if ({top, depth, err} !== {8'd8, PW'(8), 1'b1}) $display("FAIL overflow top/depth/err=%0d/%0d/%b required 8/8/1", top, depth, err);
        else n_pass++;
        drive_cmd(CMD_POP, 8'h00, 3'd0, x, a, b);
        n_checks++;
        if ({top, depth, err} !== {8'd7, PW'(7), 1'b1}) $display("FAIL pop_after_overflow top/depth/err=%0d/%0d/%b required 7/7/1", top, depth, err);
        else n_pass++;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        n_checks++;
        if ({top, depth, err} !== {8'd0, PW'(0), 1'b0}) $display("FAIL clear top/depth/err=%0d/%0d/%b required 0/0/0", top, depth, err);
        else n_pass++;
    endtask

    task automatic test_underflow();
        bit x; logic [7:0] a; logic [7:0] b;
        drive_cmd(CMD_PUSH, 8'd7, 3'd0, x, a, b);
        drive_cmd(CMD_OP, 8'h00, ALU_ADD, x, a, b);
        n_checks++;
        if ({busy, cmd_ready, top, depth, err} !== {1'b0, 1'b1, 8'd7, PW'(1), 1'b1}) begin
            $display("FAIL op_short busy/ready/top/depth/err=%b/%b/%0d/%0d/%b required 0/1/7/1/1",
                     busy, cmd_ready, top, depth, err);
        end else n_pass++;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        drive_cmd(CMD_POP, 8'h00, 3'd0, x, a, b);
        n_checks++;
        if ({top, depth, err} !== {8'd0, PW'(0), 1'b1}) $display("FAIL pop_empty top/depth/err=%0d/%0d/%b required 0/0/1", top, depth, err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit x; logic [7:0] a; logic [7:0] b;
        logic [7:0] res;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd11, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd4, 3'd0, x, a, b);
        res = 8'd7;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = CMD_OP; cmd_opc = ALU_SUB; cmd_data = 8'h00;
        @(posedge clk); #1;
        cmd_kind = CMD_PUSH; cmd_data = 8'd9;
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01) $display("FAIL b2b_exec ready/busy=%b/%b required 0/1", cmd_ready, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({cmd_ready, top, depth} !== {1'b1, res, PW'(1)}) $display("FAIL b2b_writeback ready/top/depth=%b/%0d/%0d required 1/7/1", cmd_ready, top, depth);
        else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if ({top, depth} !== {8'd9, PW'(2)}) $display("FAIL b2b_push top/depth=%0d/%0d required 9/2", top, depth);
        else n_pass++;
        mq.delete(); mq.push_back(res); mq.push_back(8'd9);
        drive_cmd(CMD_POP, 8'h00, 3'd0, x, a, b);
        n_checks++;
        if ({top, depth, err} !== {m_top(), PW'(mq.size()), m_err}) $display("FAIL b2b_pop top/depth/err=%0d/%0d/%b required %0d/%0d/%b", top, depth, err, m_top(), mq.size(), m_err);
        else n_pass++;
    endtask

    task automatic test_reset_exec();
        bit x; logic [7:0] a; logic [7:0] b;
        drive_cmd(CMD_CLEAR, 8'h00, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd10, 3'd0, x, a, b);
        drive_cmd(CMD_PUSH, 8'd20, 3'd0, x, a, b);
        drive_cmd(CMD_OP, 8'h00, ALU_ADD, x, a, b);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({depth, busy, alu_opc, alu_a, alu_b, cmd_ready, top} !== '0) begin
            $display("FAIL reset_in_exec depth/busy/opc/a/b/ready/top=%0d/%b/%0d/%h/%h/%b/%h required all 0",
                     depth, busy, alu_opc, alu_a, alu_b, cmd_ready, top);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_exec_release ready=%b required 1", cmd_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({depth, top, busy, err} !== {PW'(0), 8'h00, 1'b0, 1'b0}) $display("FAIL no_writeback depth/top/busy/err=%0d/%h/%b/%b required 0/0/0/0", depth, top, busy, err);
        else n_pass++;
        mq.delete();
        m_err = 1'b0;
    endtask

    task automatic test_random();
        bit x; logic [7:0] a; logic [7:0] b;
        logic [1:0] k; logic [7:0] d; logic [2:0] o;
        int r;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r < 9)       k = CMD_PUSH;
            else if (r < 15) k = CMD_OP;
            else if (r < 19) k = CMD_POP;
            else             k = CMD_CLEAR;
            d = 8'($urandom);
            o = 3'($urandom_range(0, 7));
            drive_cmd(k, d, o, x, a, b);
            if (x) begin
                n_checks++;
                if ({busy, alu_opc, alu_a, alu_b} !== {1'b1, o, a, b}) begin
                    $display("FAIL rand_exec[%0d] busy/opc/a/b=%b/%0d/%h/%h required 1/%0d/%h/%h",
                             n, busy, alu_opc, alu_a, alu_b, o, a, b);
                end else n_pass++;
                @(posedge clk); #1;
            end
            n_checks++;
            if ({top, depth, err} !== {m_top(), PW'(mq.size()), m_err}) begin
                $display("FAIL rand_state[%0d] top/depth/err=%h/%0d/%b required %h/%0d/%b",
                         n, top, depth, err, m_top(), mq.size(), m_err);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_wrap();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_exec();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
